// File: rtl/prelu_pkg.sv
// Shared constants and the fixed-point round/saturate helper for the PReLU stream.
package prelu_pkg;
  localparam int WIDTH = 32;
  localparam int FBITS = 27;

  localparam logic [1:0] MODE_PREL   = 2'd0;
  localparam logic [1:0] MODE_LEAKY  = 2'd1;
  localparam logic [1:0] MODE_BYPASS = 2'd2;
  localparam logic [1:0] MODE_RELU   = 2'd3;

  // 0.25 in Q(WIDTH-FBITS).FBITS
  localparam logic [WIDTH-1:0] ALPHA_INIT = WIDTH'(1) << (FBITS - 2);

  typedef struct packed {
    logic             sat;
    logic [WIDTH-1:0] y;
  } rs_t;

  // Round half up, then clamp the 2*WIDTH product back to WIDTH bits.
  function automatic rs_t round_sat(input logic signed [2*WIDTH-1:0] p);
    logic signed [2*WIDTH-1:0] half;
    logic signed [2*WIDTH-1:0] r;
    rs_t o;
    half           = '0;
    half[FBITS-1]  = 1'b1;
    r              = p + half;
    r              = r >>> FBITS;
    o.sat          = !((&r[2*WIDTH-1:WIDTH-1]) || (~|r[2*WIDTH-1:WIDTH-1]));
    if (!o.sat)             o.y = r[WIDTH-1:0];
    else if (r[2*WIDTH-1])  o.y = {1'b1, {(WIDTH-1){1'b0}}};
    else                    o.y = {1'b0, {(WIDTH-1){1'b1}}};
    return o;
  endfunction
endpackage

// File: rtl/prelu_lane.sv
// One lane: S1 sample/slope capture, S2 activation with round/saturate.
module prelu_lane
  import prelu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] slope_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] y_o,
  output logic             sat_o
);
  logic [WIDTH-1:0]          x_q, slope_q, y_q, y_d;
  logic signed [2*WIDTH-1:0] prod;
  rs_t                       rs;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      slope_q <= '0;
      y_q     <= '0;
    end else if (en_i) begin
      x_q     <= x_i;
      slope_q <= slope_i;
      y_q     <= y_d;
    end
  end

  // mode_i is already the S1 copy, aligned with x_q/slope_q
  always_comb begin
    prod  = $signed(x_q) * $signed(slope_q);
    rs    = round_sat(prod);
    y_d   = x_q;
    sat_o = 1'b0;
    if (x_q[WIDTH-1]) begin
      case (mode_i)
        MODE_PREL, MODE_LEAKY: begin
          y_d   = rs.y;
          sat_o = rs.sat;
        end
        MODE_RELU: y_d = '0;
        default:   y_d = x_q;
      endcase
    end
  end

  assign y_o = y_q;
endmodule

// File: rtl/prelu_stream.sv
// Multi-lane streaming PReLU: handshake, channel counter, slope table and the
// valid/last/ch pipeline around LANES datapath lanes.
module prelu_stream
  import prelu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int NUM_CH = 16,
  parameter int CW     = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   cfg_we,
  input  logic [CW-1:0]          cfg_addr,
  input  logic [WIDTH-1:0]       cfg_slope,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*WIDTH-1:0] m_data,
  output logic                   m_last,
  output logic [CW-1:0]          m_ch,
  output logic                   sat_flag
);
  logic             en, acc;
  logic [CW-1:0]    ch_q, ch_d, ch1_q, m_ch_q;
  logic [WIDTH-1:0] slope_q [NUM_CH];
  logic [WIDTH-1:0] slope_sel;
  logic [1:0]       vld_q;
  logic [1:0]       mode1_q;
  logic             last1_q, m_last_q, sat_q;
  logic [LANES-1:0] lane_sat;

  assign en      = ~vld_q[1] | m_ready;
  assign s_ready = en;
  assign acc     = s_valid & en;

  always_comb begin
    ch_d = ch_q;
    if (acc) ch_d = (s_last || ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
  end

  // Read before this edge's write lands, so a same-cycle cfg_we is seen next beat
  assign slope_sel = (mode == MODE_LEAKY) ? slope_q[0] : slope_q[ch_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) slope_q[i] <= ALPHA_INIT;
    end else if (cfg_we && 32'(cfg_addr) < NUM_CH) begin
      slope_q[cfg_addr] <= cfg_slope;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q     <= '0;
      vld_q    <= '0;
      mode1_q  <= MODE_PREL;
      ch1_q    <= '0;
      last1_q  <= 1'b0;
      m_ch_q   <= '0;
      m_last_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      ch_q <= ch_d;
      if (en) begin
        vld_q    <= {vld_q[0], acc};
        mode1_q  <= mode;
        ch1_q    <= ch_q;
        last1_q  <= s_last;
        m_ch_q   <= ch1_q;
        m_last_q <= last1_q;
        if (vld_q[0] && |lane_sat) sat_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    prelu_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .x_i    (s_data[i*WIDTH +: WIDTH]),
      .slope_i(slope_sel),
      .mode_i (mode1_q),
      .y_o    (m_data[i*WIDTH +: WIDTH]),
      .sat_o  (lane_sat[i])
    );
  end

  assign m_valid  = vld_q[1];
  assign m_last   = m_last_q;
  assign m_ch     = m_ch_q;
  assign sat_flag = sat_q;
endmodule

// File: doc/prelu_stream.md
# prelu_stream

Streaming, multi-lane, multi-channel fixed-point PReLU activation for the SEGAN generator/discriminator datapath. It sits between a convolution output stage and the next layer's input buffer. Each accepted beat carries LANES samples belonging to one channel. A per-channel learnable slope table, selectable activation mode, round-half-up and saturating multiply are applied, with a 2-cycle valid/ready pipeline at full throughput.

## Interface
- WIDTH, 32, sample and slope width, signed two's complement
- FBITS, 27, fractional bits of samples and slopes (Q(WIDTH-FBITS).FBITS)
- LANES, 4, samples per beat, all from the same channel
- NUM_CH, 16, channel count and slope-table depth (≥2)
- CW, $clog2(NUM_CH), channel index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  2  activation mode, sampled per accepted beat
- cfg_we  in  1  slope-table write strobe
- cfg_addr  in  CW  slope-table write address
- cfg_slope  in  WIDTH  slope value to write
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  LANES*WIDTH  samples; lane i at [i*WIDTH +: WIDTH]
- s_last  in  1  last beat of frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  LANES*WIDTH  activated samples, same lane packing
- m_last  out  1  s_last delayed with its beat
- m_ch  out  CW  channel index of the output beat
- sat_flag  out  1  sticky: any lane of any output beat saturated

## Operation
- Modes: 0 PREL: negative x → x·slope[ch]; 1 LEAKY: negative x → x·slope[0]; 2 BYPASS: y=x; 3 RELU: negative x → 0. Non-negative x (sign bit 0, including 0) always → y=x.
- Channel counter ch: 0 after reset. On each accepted beat, ch increments; wraps NUM_CH-1 → 0. An accepted beat with s_last=1 forces next ch=0, with priority over wrap.
- Multiply: full 2·WIDTH signed product; add 2^(FBITS-1); arithmetic shift right FBITS (round half up); saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Saturation: any clamped lane sets sat_flag when its beat enters the output register. Cleared only by rst.
- Slope table: NUM_CH × WIDTH registers, all reset to ALPHA_INIT = 0.25 (1<<(FBITS-2)).
  - cfg_we writes cfg_slope to entry cfg_addr at the clock edge.
  - Slope and mode are captured when a beat is accepted.
  - A write in the same cycle as acceptance of a beat using that entry: the beat uses the OLD value. The new value applies from the next accepted beat.
- Out-of-range cfg_addr (≥ NUM_CH, non-power-of-2 depth): write ignored.

## Timing
- Two register stages. S1 registers x, slope, mode, ch and last. S2 performs round/saturate and is the output register.
- Latency: a beat accepted at edge n appears on m_data after edge n+2, if not stalled. Throughput is 1 beat/cycle.
- Advance enable: en = ~m_valid | m_ready. S1 loads when en; S2 loads from S1 when en.
- s_ready = en (combinational from m_valid, m_ready; no path from s_valid).
- Stall holds: while m_valid & ~m_ready, m_data, m_last and m_ch are held stable and s_ready=0.
- Bubbles propagate: invalid S1 yields m_valid=0 after en.
- Reset values: m_valid=0, m_data=0, m_last=0, m_ch=0, sat_flag=0, s_ready=1 one cycle after reset deasserts (en true with m_valid=0), ch=0, S1 valid=0, slopes=ALPHA_INIT.
- Reset mid-operation: in-flight beats are discarded, never emitted.

## Structure
- Package prelu_pkg:
  - MODE_PREL/LEAKY/BYPASS/RELU localparams
  - ALPHA_INIT function of FBITS
  - round_sat function (2·WIDTH product → WIDTH plus sat bit)
- Sub-module prelu_lane: one lane's S1-data/S2 datapath (sign test, multiply, round, saturate), instantiated LANES times.
- The top level owns the handshake, ch counter, slope table, valid/last/ch pipeline and sat_flag OR-reduction.

## Test plan
- Reset, then one PREL beat on ch0: x=0xF800_0000 (−1.0), default slope → m_data lane=0xFE00_0000 (−0.25). Positive lane 0x0400_0000 passes unchanged. Beat appears 2 cycles after acceptance.
- Saturation: slope[0]=0xF000_0000 (−2.0), x=0x8000_0000 → 0x7FFF_FFFF, sat_flag=1 and stays 1 until rst.
- Rounding: slope=0x0400_0000 (0.5), x=0xFFFF_FFFF → 0x0000_0000. x=0xFFFF_FFFD → 0xFFFF_FFFF (−1.5 LSB rounds up to −1 LSB).
- Channel wrap/last: NUM_CH+2 beats with distinct slopes per entry → m_ch sequence 0..15,0,1 using matching slopes. s_last on beat 5 → next m_ch=0.
- Backpressure: random m_ready toggling over 200 beats → no loss, duplication or reordering; m_data stable while m_valid & ~m_ready.
- Same-cycle cfg_we to slope[3] while accepting a ch3 beat → that beat uses the old slope, the next ch3 beat the new one. Mid-stream rst → m_valid=0 next cycle, ch=0, slopes back to 0x0200_0000.
